// File: rtl/isqrt_seq.sv
// Sequential integer square root: restoring digit-by-digit, one root bit per clock.
// Recovers n from n^2 and reports the remainder radicand - root^2.
module isqrt_seq #(
  parameter int WIDTH_IN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_IN-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH_IN/2-1:0]   out_root,
  output logic [WIDTH_IN/2:0]     out_rem,
  output logic                    out_exact
);

  localparam int WR = WIDTH_IN / 2;
  localparam int IW = (WR > 1) ? $clog2(WR) : 1;
  localparam int DW = WR + 3;
  localparam logic [IW-1:0] ITER_FIRST = IW'(WR - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((WIDTH_IN % 2) != 0 || WIDTH_IN < 2) begin : g_bad_width
    $error("isqrt_seq: WIDTH_IN must be even and >= 2");
  end

  logic [1:0]          state_q, state_d;
  logic [WIDTH_IN-1:0] sh_q, sh_d;
  logic [WR:0]         rem_q, rem_d;
  logic [WR-1:0]       root_q, root_d;
  logic [IW-1:0]       iter_q, iter_d;
  logic [WR-1:0]       outRoot_q, outRoot_d;
  logic [WR:0]         outRem_q, outRem_d;
  logic                outExact_q, outExact_d;

  // Trial subtraction carries two spare bits so the sign bit is a clean borrow.
  logic [DW-1:0] trial;
  logic [DW-1:0] subtrahend;
  logic [DW-1:0] diff;
  logic          fits;
  logic [WR:0]   remNext;
  logic [WR-1:0] rootNext;

  assign trial      = {rem_q, sh_q[WIDTH_IN-1 -: 2]};
  assign subtrahend = {1'b0, root_q, 2'b01};
  assign diff       = trial - subtrahend;
  assign fits       = ~diff[DW-1];
  assign remNext    = fits ? diff[WR:0] : trial[WR:0];
  assign rootNext   = fits ? ((root_q << 1) | WR'(1)) : (root_q << 1);

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    rem_d      = rem_q;
    root_d     = root_q;
    iter_d     = iter_q;
    outRoot_d  = outRoot_q;
    outRem_d   = outRem_q;
    outExact_d = outExact_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          rem_d   = '0;
          root_d  = '0;
          iter_d  = ITER_FIRST;
          state_d = CALC;
        end
      end
      CALC: begin
        sh_d   = sh_q << 2;
        rem_d  = remNext;
        root_d = rootNext;
        if (iter_q == '0) begin
          outRoot_d  = rootNext;
          outRem_d   = remNext;
          outExact_d = (remNext == '0);
          state_d    = DONE;
        end else begin
          iter_d = iter_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      iter_q     <= '0;
      outRoot_q  <= '0;
      outRem_q   <= '0;
      outExact_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      iter_q     <= iter_d;
      outRoot_q  <= outRoot_d;
      outRem_q   <= outRem_d;
      outExact_q <= outExact_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_root  = outRoot_q;
  assign out_rem   = outRem_q;
  assign out_exact = outExact_q;

`ifndef SYNTHESIS
  // Simulation-only copy of the accepted radicand for the result invariants.
  localparam int SW = WIDTH_IN + 1;
  logic [WIDTH_IN-1:0] radShadow_q;
  logic [SW-1:0]       sqSum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      radShadow_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      radShadow_q <= in_data;
    end
  end

  assign sqSum = SW'(outRoot_q) * SW'(outRoot_q) + SW'(outRem_q);

  a_square_sum : assert property (@(posedge clk) disable iff (rst)
    (state_q == DONE) |-> (sqSum == {1'b0, radShadow_q}));

  a_rem_bound : assert property (@(posedge clk) disable iff (rst)
    (state_q == DONE) |-> (outRem_q <= {outRoot_q, 1'b0}));
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: directed cases, backpressure, reset abort,
// a full 8-bit sweep with random out_ready, and a 16-bit instance.
module tb_isqrt_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_exact;
  logic [7:0] in_data;
  logic [3:0] out_root;
  logic [4:0] out_rem;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_exact;
  logic [15:0] w_in_data;
  logic [7:0]  w_out_root;
  logic [8:0]  w_out_rem;

  int vectors = 0;
  int errors  = 0;

  isqrt_seq #(.WIDTH_IN(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_root(out_root), .out_rem(out_rem), .out_exact(out_exact)
  );

  isqrt_seq #(.WIDTH_IN(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_root(w_out_root), .out_rem(w_out_rem), .out_exact(w_out_exact)
  );

  // Reference: largest r with r*r <= n, found by plain counting.
  function automatic int ref_root(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // Drives one 8-bit transaction; results are compared by the caller.
  task automatic run8(input logic [7:0] n, input bit rnd_ready,
                      output logic [3:0] root, output logic [4:0] rem,
                      output logic ex, output int lat, output bit to);
    int k;
    to = 0; lat = 0; root = '0; rem = '0; ex = 1'b0;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin to = 1; return; end
    in_valid = 1'b1; in_data = n;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom);
    while (!out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    if (!out_valid) begin to = 1; return; end
    root = out_root; rem = out_rem; ex = out_exact;
    k = 0;
    do begin
      out_ready = (rnd_ready && k < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      k++;
      if (!out_ready) @(negedge clk);
    end while (!out_ready);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run16(input logic [15:0] n,
                       output logic [7:0] root, output logic [8:0] rem,
                       output logic ex, output int lat, output bit to);
    int k;
    to = 0; lat = 0; root = '0; rem = '0; ex = 1'b0;
    @(negedge clk);
    k = 0;
    while (!w_in_ready && k < 50) begin @(negedge clk); k++; end
    if (!w_in_ready) begin to = 1; return; end
    w_in_valid = 1'b1; w_in_data = n;
    @(posedge clk);
    @(negedge clk);
    w_in_valid = 1'b0;
    while (!w_out_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    if (!w_out_valid) begin to = 1; return; end
    root = w_out_root; rem = w_out_rem; ex = w_out_exact;
    w_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_root, out_rem, out_exact} !== {1'b1, 1'b0, 4'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset8: got rdy=%b vld=%b root=%0d rem=%0d ex=%b, need 1 0 0 0 0",
               in_ready, out_valid, out_root, out_rem, out_exact);
    end
    vectors++;
    if ({w_in_ready, w_out_valid, w_out_root, w_out_rem, w_out_exact} !== {1'b1, 1'b0, 8'd0, 9'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset16: got rdy=%b vld=%b root=%0d rem=%0d ex=%b, need 1 0 0 0 0",
               w_in_ready, w_out_valid, w_out_root, w_out_rem, w_out_exact);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    logic [3:0] r; logic [4:0] m; logic e; int lat; bit to;
    run8(8'd0, 1'b0, r, m, e, lat, to);
    vectors++;
    if (to || lat != 4) begin
      errors++;
      $display("[TB] FAIL zero_latency: got %0d edges (timeout=%0b), need 4", lat, to);
    end
    vectors++;
    if ({r, m, e} !== {4'd0, 5'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL zero_result: got root=%0d rem=%0d ex=%b, need 0 0 1", r, m, e);
    end
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_return_idle: got rdy=%b vld=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [7:0] vin [3] = '{8'd225, 8'd255, 8'd200};
    logic [3:0] vr  [3] = '{4'd15, 4'd15, 4'd14};
    logic [4:0] vm  [3] = '{5'd0, 5'd30, 5'd4};
    logic       ve  [3] = '{1'b1, 1'b0, 1'b0};
    logic [3:0] r; logic [4:0] m; logic e; int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      run8(vin[i], 1'b0, r, m, e, lat, to);
      vectors++;
      if (to || {r, m, e} !== {vr[i], vm[i], ve[i]}) begin
        errors++;
        $display("[TB] FAIL directed_%0d: got root=%0d rem=%0d ex=%b to=%0b, need %0d %0d %b",
                 vin[i], r, m, e, to, vr[i], vm[i], ve[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd144;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'd7;
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      vectors++;
      if ({out_valid, in_ready, out_root, out_rem, out_exact} !== {1'b1, 1'b0, 4'd12, 5'd0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL backpressure_hold_%0d: got vld=%b rdy=%b root=%0d rem=%0d ex=%b, need 1 0 12 0 1",
                 c, out_valid, in_ready, out_root, out_rem, out_exact);
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_release: got vld=%b rdy=%b, need 0 1", out_valid, in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL no_phantom_accept_%0d: got vld=%b rdy=%b, need 0 1", c, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [3:0] r; logic [4:0] m; logic e; int lat; bit to;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd99;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_not_ready: got rdy=%b, need 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, in_ready, out_root, out_rem, out_exact} !== {1'b0, 1'b1, 4'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_abort: got vld=%b rdy=%b root=%0d rem=%0d ex=%b, need 0 1 0 0 0",
               out_valid, in_ready, out_root, out_rem, out_exact);
    end
    @(negedge clk);
    rst = 1'b0;
    run8(8'd99, 1'b0, r, m, e, lat, to);
    vectors++;
    if (to || {r, m, e} !== {4'd9, 5'd18, 1'b0}) begin
      errors++;
      $display("[TB] FAIL after_reset_99: got root=%0d rem=%0d ex=%b to=%0b, need 9 18 0", r, m, e, to);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] r; logic [4:0] m; logic e; int lat; bit to;
    int er, em;
    for (int n = 0; n < 256; n++) begin
      run8(8'(n), 1'b1, r, m, e, lat, to);
      er = ref_root(n);
      em = n - er * er;
      vectors++;
      if (to || lat != 4 || int'(r) != er || int'(m) != em || e !== (em == 0)) begin
        errors++;
        $display("[TB] FAIL sweep_%0d: got root=%0d rem=%0d ex=%b lat=%0d to=%0b, need %0d %0d %0b lat 4",
                 n, r, m, e, lat, to, er, em, (em == 0));
      end
    end
  endtask

  task automatic test_wide();
    logic [7:0] r; logic [8:0] m; logic e; int lat; bit to;
    int n, er, em;
    for (int i = 0; i < 22; i++) begin
      n = (i == 0) ? 65535 : (i == 1) ? 40000 : int'($urandom_range(0, 65535));
      run16(16'(n), r, m, e, lat, to);
      er = ref_root(n);
      em = n - er * er;
      vectors++;
      if (to || lat != 8 || int'(r) != er || int'(m) != em || e !== (em == 0)) begin
        errors++;
        $display("[TB] FAIL wide_%0d: got root=%0d rem=%0d ex=%b lat=%0d to=%0b, need %0d %0d %0b lat 8",
                 n, r, m, e, lat, to, er, em, (em == 0));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_sweep();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
